// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared types for the cache-side memory arbiter
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_select.sv
// rtl/rr_select.sv - combinational winner select, round-robin from ptr or fixed lowest-index
module rr_select #(
    parameter int NUM_CH     = 2,
    parameter int IDX_W      = $clog2(NUM_CH),
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [IDX_W-1:0]  ptr_i,
    output logic [NUM_CH-1:0] gnt_o,
    output logic [IDX_W-1:0]  idx_o
);

    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            // Fixed priority ignores ptr and scans upward from channel 0.
            cand = FIXED_PRIO ? IDX_W'(k) : IDX_W'((int'(ptr_i) + k) % NUM_CH);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - N-channel cache request arbiter onto one downstream memory port
module mem_arbiter
    import lc3b_types::*;
#(
    parameter int NUM_CH     = 2,
    parameter int ADDR_W     = 16,
    parameter int LINE_W     = 128,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_CH-1:0]              ch_read,
    input  logic [NUM_CH-1:0]              ch_write,
    input  logic [NUM_CH-1:0][ADDR_W-1:0]  ch_address,
    input  logic [NUM_CH-1:0][LINE_W-1:0]  ch_wdata,
    output logic [NUM_CH-1:0][LINE_W-1:0]  ch_rdata,
    output logic [NUM_CH-1:0]              ch_resp,
    output logic                           l2_read,
    output logic                           l2_write,
    output logic [ADDR_W-1:0]              l2_address,
    output logic [LINE_W-1:0]              l2_wdata,
    input  logic [LINE_W-1:0]              l2_rdata,
    input  logic                           l2_resp
);

    localparam int IDX_W = $clog2(NUM_CH);

    arb_state_t        state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  gidx_q, gidx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              wr_q, wr_d;
    logic              rd_q, rd_d;

    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] sel_gnt;
    logic [IDX_W-1:0]  sel_idx;
    logic              busy;
    logic              resp_fire;

    assign req = ch_read | ch_write;

    rr_select #(
        .NUM_CH     (NUM_CH),
        .IDX_W      (IDX_W),
        .FIXED_PRIO (FIXED_PRIO)
    ) u_rr_select (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (sel_gnt),
        .idx_o (sel_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gidx_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        case (state_q)
            IDLE: begin
                if (|sel_gnt) begin
                    state_d = BUSY;
                    gidx_d  = sel_idx;
                    addr_d  = ch_address[sel_idx];
                    wdata_d = ch_wdata[sel_idx];
                    // A channel raising both strobes is treated as a write.
                    wr_d    = ch_write[sel_idx];
                    rd_d    = ~ch_write[sel_idx];
                    if (!FIXED_PRIO) begin
                        ptr_d = (sel_idx == IDX_W'(NUM_CH - 1)) ? '0 : sel_idx + IDX_W'(1);
                    end
                end
            end
            BUSY: begin
                if (l2_resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q == BUSY);
        l2_read    = busy & rd_q;
        l2_write   = busy & wr_q;
        l2_address = addr_q;
        l2_wdata   = wdata_q;
        resp_fire  = busy & l2_resp & ~reset;
        ch_resp    = '0;
        ch_rdata   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (resp_fire && (gidx_q == IDX_W'(i))) begin
                ch_resp[i]  = 1'b1;
                ch_rdata[i] = l2_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench, round-robin and fixed-priority instances
module tb_mem_arbiter;

    localparam int NCH = 4;
    localparam int AW  = 16;
    localparam int LW  = 128;

    logic clk;
    logic reset;

    logic [NCH-1:0]          ch_read    [2];
    logic [NCH-1:0]          ch_write   [2];
    logic [NCH-1:0][AW-1:0]  ch_address [2];
    logic [NCH-1:0][LW-1:0]  ch_wdata   [2];
    logic [NCH-1:0][LW-1:0]  ch_rdata   [2];
    logic [NCH-1:0]          ch_resp    [2];
    logic                    l2_read    [2];
    logic                    l2_write   [2];
    logic [AW-1:0]           l2_address [2];
    logic [LW-1:0]           l2_wdata   [2];
    logic [LW-1:0]           l2_rdata   [2];
    logic                    l2_resp    [2];

    mem_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .LINE_W(LW), .FIXED_PRIO(1'b0)) u_rr (
        .clk(clk), .reset(reset),
        .ch_read(ch_read[0]), .ch_write(ch_write[0]), .ch_address(ch_address[0]),
        .ch_wdata(ch_wdata[0]), .ch_rdata(ch_rdata[0]), .ch_resp(ch_resp[0]),
        .l2_read(l2_read[0]), .l2_write(l2_write[0]), .l2_address(l2_address[0]),
        .l2_wdata(l2_wdata[0]), .l2_rdata(l2_rdata[0]), .l2_resp(l2_resp[0])
    );

    mem_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .LINE_W(LW), .FIXED_PRIO(1'b1)) u_fp (
        .clk(clk), .reset(reset),
        .ch_read(ch_read[1]), .ch_write(ch_write[1]), .ch_address(ch_address[1]),
        .ch_wdata(ch_wdata[1]), .ch_rdata(ch_rdata[1]), .ch_resp(ch_resp[1]),
        .l2_read(l2_read[1]), .l2_write(l2_write[1]), .l2_address(l2_address[1]),
        .l2_wdata(l2_wdata[1]), .l2_rdata(l2_rdata[1]), .l2_resp(l2_resp[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requester side: one pending request per channel, held until its completion.
    bit            p_val   [2][NCH];
    bit            p_rd    [2][NCH];
    bit            p_wr    [2][NCH];
    bit            p_re    [2][NCH];
    logic [AW-1:0] p_addr  [2][NCH];
    logic [LW-1:0] p_wdata [2][NCH];

    // Reference model: at most one outstanding transaction per arbiter.
    bit            m_busy  [2];
    bit            m_wr    [2];
    bit            m_fresh [2];
    int            m_ch    [2];
    int            m_ptr   [2];
    int            r_cnt   [2];
    logic [AW-1:0] m_addr  [2];
    logic [LW-1:0] m_wdata [2];

    int  fixed_lat;
    bit  stray;
    bit  rnd_mode;
    int  cyc;
    int  n_tests;
    int  n_fail;
    int  glog [2][$];
    int  gcyc [2][$];

    logic [NCH-1:0] last_resp  [2];
    logic [LW-1:0]  last_l2rd  [2];
    logic [LW-1:0]  last_rdata1;

    task automatic check(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic pend(input int d, input int c, input bit rd, input bit wr,
                        input logic [AW-1:0] a, input logic [LW-1:0] w, input bit re);
        p_val[d][c]   = 1'b1;
        p_rd[d][c]    = rd;
        p_wr[d][c]    = wr;
        p_addr[d][c]  = a;
        p_wdata[d][c] = w;
        p_re[d][c]    = re;
    endtask

    function automatic logic [LW-1:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic compare(input int d);
        logic [NCH-1:0] exp_resp;
        exp_resp = '0;
        if (m_busy[d] && l2_resp[d] && !reset) exp_resp[m_ch[d]] = 1'b1;
        check($sformatf("d%0d_ch_resp", d), LW'(ch_resp[d]), LW'(exp_resp));
        check($sformatf("d%0d_l2_read", d), LW'(l2_read[d]), LW'(m_busy[d] && !m_wr[d]));
        check($sformatf("d%0d_l2_write", d), LW'(l2_write[d]), LW'(m_busy[d] && m_wr[d]));
        if (m_busy[d]) begin
            check($sformatf("d%0d_l2_address", d), LW'(l2_address[d]), LW'(m_addr[d]));
            check($sformatf("d%0d_l2_wdata", d), l2_wdata[d], m_wdata[d]);
        end else if (m_fresh[d]) begin
            check($sformatf("d%0d_rst_address", d), LW'(l2_address[d]), '0);
            check($sformatf("d%0d_rst_wdata", d), l2_wdata[d], '0);
        end
        for (int c = 0; c < NCH; c++) begin
            check($sformatf("d%0d_ch_rdata%0d", d, c), ch_rdata[d][c],
                  exp_resp[c] ? l2_rdata[d] : '0);
            if (ch_resp[d][c]) begin
                glog[d].push_back(c);
                gcyc[d].push_back(cyc);
            end
        end
        last_resp[d] = ch_resp[d];
        last_l2rd[d] = l2_rdata[d];
        if (d == 0) last_rdata1 = ch_rdata[0][1];
    endtask

    task automatic advance(input int d);
        int done_c;
        int w;
        int c;
        done_c = -1;
        if (reset) begin
            m_busy[d]  = 1'b0;
            m_ptr[d]   = 0;
            m_fresh[d] = 1'b1;
        end else if (m_busy[d]) begin
            if (l2_resp[d]) begin
                m_busy[d]         = 1'b0;
                done_c            = m_ch[d];
                p_val[d][done_c]  = 1'b0;
            end else if (r_cnt[d] > 0) begin
                r_cnt[d]--;
            end
        end else begin
            w = -1;
            for (int k = 0; k < NCH; k++) begin
                c = (d == 1) ? k : (m_ptr[d] + k) % NCH;
                if (w < 0 && (ch_read[d][c] || ch_write[d][c])) w = c;
            end
            if (w >= 0) begin
                m_busy[d]  = 1'b1;
                m_fresh[d] = 1'b0;
                m_ch[d]    = w;
                m_wr[d]    = ch_write[d][w];
                m_addr[d]  = ch_address[d][w];
                m_wdata[d] = ch_wdata[d][w];
                if (d == 0) m_ptr[d] = (w + 1) % NCH;
                r_cnt[d] = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
            end
        end
        for (int k = 0; k < NCH; k++) begin
            if (k == done_c) continue;
            if (p_val[d][k]) begin
                if (rnd_mode && $urandom_range(0, 7) == 0) begin
                    p_addr[d][k]  = AW'($urandom);
                    p_wdata[d][k] = rnd_line();
                end
            end else if (p_re[d][k]) begin
                p_val[d][k] = 1'b1;
            end else if (rnd_mode && $urandom_range(0, 3) == 0) begin
                w = int'($urandom_range(0, 2));
                pend(d, k, w != 1, w != 0, AW'($urandom), rnd_line(), 1'b0);
            end
        end
    endtask

    task automatic step();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < NCH; c++) begin
                ch_read[d][c]    = p_val[d][c] && p_rd[d][c];
                ch_write[d][c]   = p_val[d][c] && p_wr[d][c];
                ch_address[d][c] = p_addr[d][c];
                ch_wdata[d][c]   = p_wdata[d][c];
            end
            l2_rdata[d] = rnd_line();
            if (reset)          l2_resp[d] = 1'b0;
            else if (m_busy[d]) l2_resp[d] = (r_cnt[d] == 0);
            else                l2_resp[d] = stray && ($urandom_range(0, 7) == 0);
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) compare(d);
        for (int d = 0; d < 2; d++) advance(d);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic drain();
        rnd_mode = 1'b0;
        stray    = 1'b0;
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < NCH; c++) p_re[d][c] = 1'b0;
        run(60);
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < NCH; c++)
                check($sformatf("d%0d_drain%0d", d, c), LW'(p_val[d][c]), '0);
    endtask

    task automatic clear_logs();
        for (int d = 0; d < 2; d++) begin
            glog[d].delete();
            gcyc[d].delete();
        end
    endtask

    int             exp_rr [5];
    int             exp_fp [5];
    logic [LW-1:0]  a5_line;

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0;
        fixed_lat = 0; stray = 1'b0; rnd_mode = 1'b0;
        exp_rr = '{0, 1, 2, 3, 0};
        exp_fp = '{0, 1, 0, 1, 0};
        a5_line = {16{8'hA5}};
        for (int d = 0; d < 2; d++) begin
            m_busy[d] = 1'b0; m_wr[d] = 1'b0; m_fresh[d] = 1'b1;
            m_ch[d] = 0; m_ptr[d] = 0; r_cnt[d] = 0;
            m_addr[d] = '0; m_wdata[d] = '0;
            for (int c = 0; c < NCH; c++) begin
                p_val[d][c] = 1'b0; p_rd[d][c] = 1'b0; p_wr[d][c] = 1'b0; p_re[d][c] = 1'b0;
                p_addr[d][c] = '0; p_wdata[d][c] = '0;
            end
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        run(3);
        check("rst_l2_read", LW'(l2_read[0]), '0);
        check("rst_l2_write", LW'(l2_write[1]), '0);
        check("rst_l2_address", LW'(l2_address[0]), '0);
        reset = 1'b0;

        // Single read on channel 1, response two cycles after the strobe.
        fixed_lat = 2;
        pend(0, 1, 1'b1, 1'b0, 16'h1230, rnd_line(), 1'b0);
        step();
        check("single_l2_read", LW'(l2_read[0]), LW'(1'b1));
        check("single_l2_write", LW'(l2_write[0]), '0);
        check("single_l2_address", LW'(l2_address[0]), LW'(16'h1230));
        run(3);
        check("single_ch_resp", LW'(last_resp[0]), LW'(4'b0010));
        check("single_rdata", last_rdata1, last_l2rd[0]);
        run(2);

        // Continuous contention: round-robin on all four, fixed priority on 0..2.
        reset = 1'b1;
        run(1);
        reset = 1'b0;
        clear_logs();
        fixed_lat = 0;
        for (int c = 0; c < NCH; c++) pend(0, c, 1'b1, 1'b0, AW'($urandom), rnd_line(), 1'b1);
        for (int c = 0; c < 3; c++) pend(1, c, 1'b1, 1'b0, AW'($urandom), rnd_line(), 1'b1);
        run(10);
        check("rr_grant_count", LW'(glog[0].size()), LW'(5));
        check("fp_grant_count", LW'(glog[1].size()), LW'(5));
        for (int k = 0; k < 5; k++) begin
            if (k < glog[0].size()) check($sformatf("rr_order%0d", k), LW'(glog[0][k]), LW'(exp_rr[k]));
            if (k < glog[1].size()) check($sformatf("fp_order%0d", k), LW'(glog[1][k]), LW'(exp_fp[k]));
            if (k + 1 < gcyc[0].size())
                check($sformatf("rr_spacing%0d", k), LW'(gcyc[0][k+1] - gcyc[0][k]), LW'(2));
        end
        drain();

        // Read and write together on one channel: write wins.
        fixed_lat = 1;
        pend(0, 0, 1'b1, 1'b1, 16'h00F0, a5_line, 1'b0);
        step();
        check("rw_l2_write", LW'(l2_write[0]), LW'(1'b1));
        check("rw_l2_read", LW'(l2_read[0]), '0);
        check("rw_l2_wdata", l2_wdata[0], a5_line);
        run(4);

        // Address change while busy must not disturb the latched transaction.
        fixed_lat = 3;
        pend(0, 0, 1'b1, 1'b0, 16'h4000, rnd_line(), 1'b0);
        step();
        p_addr[0][0] = 16'hBEEF;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("latch_addr%0d", k), LW'(l2_address[0]), LW'(16'h4000));
            step();
        end
        run(3);

        // Reset mid-transaction: no response, pointer back to 0.
        fixed_lat = 5;
        clear_logs();
        pend(0, 0, 1'b1, 1'b0, 16'h0777, rnd_line(), 1'b0);
        run(2);
        reset = 1'b1;
        pend(0, 1, 1'b1, 1'b0, 16'h0111, rnd_line(), 1'b0);
        step();
        check("rst_mid_l2_read", LW'(l2_read[0]), '0);
        check("rst_mid_no_resp", LW'(glog[0].size()), '0);
        reset = 1'b0;
        fixed_lat = 1;
        run(10);
        check("rst_after_count", LW'(glog[0].size()), LW'(2));
        if (glog[0].size() > 0) check("rst_after_first", LW'(glog[0][0]), '0);
        if (glog[0].size() > 1) check("rst_after_second", LW'(glog[0][1]), LW'(1));

        // Random traffic with random latency and stray responses while idle.
        fixed_lat = -1;
        rnd_mode  = 1'b1;
        stray     = 1'b1;
        run(3000);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
